// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (bit6=a .. bit0=g, active-high),
// the code used for non-digit patterns, and the output register state type.
package seg7_pkg;

   localparam logic [6:0] SEG7_D0    = 7'b1111110;
   localparam logic [6:0] SEG7_D1    = 7'b0110000;
   localparam logic [6:0] SEG7_D2    = 7'b1101101;
   localparam logic [6:0] SEG7_D3    = 7'b1111001;
   localparam logic [6:0] SEG7_D4    = 7'b0110011;
   localparam logic [6:0] SEG7_D5    = 7'b1011011;
   localparam logic [6:0] SEG7_D6    = 7'b1011111;
   localparam logic [6:0] SEG7_D7    = 7'b1110000;
   localparam logic [6:0] SEG7_D8    = 7'b1111111;
   localparam logic [6:0] SEG7_D9    = 7'b1111011;
   localparam logic [6:0] SEG7_BLANK = 7'b0000000;

   localparam logic [3:0] DIG_INVALID = 4'hF;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/seg7_reader_if.sv
// Valid/ready event channel carrying one decoded segment pattern.
interface seg7_reader_if;

   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_digit;
   logic       out_err;
   logic       out_blank;

   modport master (
      output out_valid,
      output out_digit,
      output out_err,
      output out_blank,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_digit,
      input  out_err,
      input  out_blank,
      output out_ready
   );

endinterface

// File: rtl/seg7_segdecode.sv
// Combinational decode of a 7-segment pattern back to a BCD digit, flagging
// the all-off pattern as blank and anything else unrecognised as an error.
module seg7_segdecode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       err,
   output logic       blank
);

   // Pattern lookup; non-digit patterns report DIG_INVALID
   always_comb begin
      digit = DIG_INVALID;
      err   = 1'b0;
      blank = 1'b0;
      case (seg)
         SEG7_D0:    digit = 4'd0;
         SEG7_D1:    digit = 4'd1;
         SEG7_D2:    digit = 4'd2;
         SEG7_D3:    digit = 4'd3;
         SEG7_D4:    digit = 4'd4;
         SEG7_D5:    digit = 4'd5;
         SEG7_D6:    digit = 4'd6;
         SEG7_D7:    digit = 4'd7;
         SEG7_D8:    digit = 4'd8;
         SEG7_D9:    digit = 4'd9;
         SEG7_BLANK: blank = 1'b1;
         default:    err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// Samples an asynchronous 7-segment bus, waits for it to hold still for
// STABLE_CYCLES synchronised samples, and emits each newly stable pattern
// as one decoded event through a single-entry valid/ready register.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      seg_in,
   input  logic            clr_overrun,
   output logic            overrun,
   seg7_reader_if.master   out_if
);

   localparam logic [7:0] STABLE_CNT = STABLE_CYCLES[7:0];

   logic [6:0] seg_s1_q, seg_s1_d;
   logic [6:0] seg_s2_q, seg_s2_d;
   logic [6:0] hist_q, hist_d;
   logic [7:0] cnt_q, cnt_d;
   out_state_e state_q, state_d;
   logic [3:0] digit_q, digit_d;
   logic       err_q, err_d;
   logic       blank_q, blank_d;
   logic       overrun_q, overrun_d;

   logic       load;
   logic       accept;
   logic       handshake;
   logic [3:0] dec_digit;
   logic       dec_err;
   logic       dec_blank;

   // Decode the pattern that the filter holds after this edge, so that a
   // single-cycle filter (load edge == accept edge) sees the new pattern
   seg7_segdecode u_decode (
      .seg   (hist_d),
      .digit (dec_digit),
      .err   (dec_err),
      .blank (dec_blank)
   );

   // Two-stage synchroniser, then a saturating run-length counter; accept
   // fires only on the edge where the count first reaches the threshold
   always_comb begin
      seg_s1_d = seg_in;
      seg_s2_d = seg_s1_q;
      hist_d   = hist_q;
      cnt_d    = cnt_q;
      load     = (seg_s2_q != hist_q);
      if (load) begin
         hist_d = seg_s2_q;
         cnt_d  = 8'd1;
      end else if (cnt_q < STABLE_CNT) begin
         cnt_d = cnt_q + 8'd1;
      end
      accept = (cnt_d == STABLE_CNT) && (load || (cnt_q != STABLE_CNT));
   end

   // Output register: load on accept when empty or when the held event is
   // leaving this cycle; otherwise a colliding accept is dropped as overrun
   always_comb begin
      state_d   = state_q;
      digit_d   = digit_q;
      err_d     = err_q;
      blank_d   = blank_q;
      overrun_d = overrun_q;
      handshake = (state_q == OUT_FULL) && out_if.out_ready;
      if (clr_overrun) begin
         overrun_d = 1'b0;
      end
      case (state_q)
         OUT_EMPTY: begin
            if (accept) begin
               state_d = OUT_FULL;
               digit_d = dec_digit;
               err_d   = dec_err;
               blank_d = dec_blank;
            end
         end
         OUT_FULL: begin
            if (accept && handshake) begin
               digit_d = dec_digit;
               err_d   = dec_err;
               blank_d = dec_blank;
            end else if (accept) begin
               overrun_d = 1'b1;
            end else if (handshake) begin
               state_d = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   // State registers; the filter starts saturated so a blank bus is silent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q  <= '0;
         seg_s2_q  <= '0;
         hist_q    <= '0;
         cnt_q     <= STABLE_CNT;
         state_q   <= OUT_EMPTY;
         digit_q   <= 4'h0;
         err_q     <= 1'b0;
         blank_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         seg_s1_q  <= seg_s1_d;
         seg_s2_q  <= seg_s2_d;
         hist_q    <= hist_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         digit_q   <= digit_d;
         err_q     <= err_d;
         blank_q   <= blank_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_if.out_valid = (state_q == OUT_FULL);
   assign out_if.out_digit = digit_q;
   assign out_if.out_err   = err_q;
   assign out_if.out_blank = blank_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: expected events are queued when a
// pattern is driven and popped whenever the DUT completes a handshake.
module tb_seg7_reader;
   import seg7_pkg::*;

   typedef struct packed {
      logic [3:0] digit;
      logic       err;
      logic       blank;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       clr_overrun;
   logic       overrun;

   int checks;
   int failures;
   exp_t exp_q[$];

   seg7_reader_if bus ();

   seg7_reader #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .clr_overrun (clr_overrun),
      .overrun     (overrun),
      .out_if      (bus.master)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard: every handshake must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL event_unexpected got digit=%h err=%b blank=%b, required none",
                     bus.out_digit, bus.out_err, bus.out_blank);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({bus.out_digit, bus.out_err, bus.out_blank} !== {e.digit, e.err, e.blank}) begin
               failures++;
               $display("[TB] FAIL event_data got digit=%h err=%b blank=%b, required digit=%h err=%b blank=%b",
                        bus.out_digit, bus.out_err, bus.out_blank, e.digit, e.err, e.blank);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      seg_in      = 7'd0;
      clr_overrun = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid cycle=%0d got %b, required 0", i, bus.out_valid);
         end
      end
      checks++;
      if ({bus.out_digit, bus.out_err, bus.out_blank, overrun} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got digit=%h err=%b blank=%b ovr=%b, required all 0",
                  bus.out_digit, bus.out_err, bus.out_blank, overrun);
      end
   endtask

   task automatic test_latency();
      bus.out_ready = 1'b1;
      seg_in = SEG7_D2;
      exp_q.push_back('{digit: 4'd2, err: 1'b0, blank: 1'b0});
      for (int e = 0; e < 5; e++) begin
         step(1);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_early edge=%0d got %b, required 0", e, bus.out_valid);
         end
      end
      step(1);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL latency_edge5 got %b, required 1", bus.out_valid);
      end
      step(1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL latency_one_cycle got %b, required 0", bus.out_valid);
      end
      step(10);
   endtask

   task automatic test_glitch();
      seg_in = SEG7_D5;
      exp_q.push_back('{digit: 4'd5, err: 1'b0, blank: 1'b0});
      step(10);
      seg_in = SEG7_D8;
      step(3);
      seg_in = SEG7_D5;
      exp_q.push_back('{digit: 4'd5, err: 1'b0, blank: 1'b0});
      step(12);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL glitch_pending got %0d queued, required 0", exp_q.size());
      end
   endtask

   task automatic test_overrun();
      bus.out_ready = 1'b0;
      seg_in = SEG7_D1;
      step(10);
      seg_in = SEG7_D7;
      step(10);
      checks++;
      if ({bus.out_valid, bus.out_digit, overrun} !== {1'b1, 4'd1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL overrun_hold got valid=%b digit=%h ovr=%b, required valid=1 digit=1 ovr=1",
                  bus.out_valid, bus.out_digit, overrun);
      end
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("[TB] FAIL overrun_clear got %b, required 0", overrun);
      end
      seg_in = SEG7_D4;
      step(5);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      checks++;
      if ({overrun, bus.out_digit} !== {1'b1, 4'd1}) begin
         failures++;
         $display("[TB] FAIL overrun_set_wins got ovr=%b digit=%h, required ovr=1 digit=1",
                  overrun, bus.out_digit);
      end
      exp_q.push_back('{digit: 4'd1, err: 1'b0, blank: 1'b0});
      bus.out_ready = 1'b1;
      step(3);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      checks++;
      if ({bus.out_valid, overrun} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL overrun_drain got valid=%b ovr=%b, required 0 0", bus.out_valid, overrun);
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b0;
      seg_in = SEG7_D3;
      exp_q.push_back('{digit: 4'd3, err: 1'b0, blank: 1'b0});
      step(10);
      seg_in = SEG7_D6;
      exp_q.push_back('{digit: 4'd6, err: 1'b0, blank: 1'b0});
      step(5);
      bus.out_ready = 1'b1;
      step(1);
      checks++;
      if ({bus.out_valid, bus.out_digit, overrun} !== {1'b1, 4'd6, 1'b0}) begin
         failures++;
         $display("[TB] FAIL b2b_replace got valid=%b digit=%h ovr=%b, required valid=1 digit=6 ovr=0",
                  bus.out_valid, bus.out_digit, overrun);
      end
      step(1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_drop got %b, required 0", bus.out_valid);
      end
   endtask

   task automatic test_err_blank();
      bus.out_ready = 1'b1;
      seg_in = 7'b0000001;
      exp_q.push_back('{digit: DIG_INVALID, err: 1'b1, blank: 1'b0});
      step(10);
      seg_in = SEG7_BLANK;
      exp_q.push_back('{digit: DIG_INVALID, err: 1'b0, blank: 1'b1});
      step(10);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL err_blank_pending got %0d queued, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      seg_in = SEG7_D9;
      step(10);
      checks++;
      if ({bus.out_valid, bus.out_digit} !== {1'b1, 4'd9}) begin
         failures++;
         $display("[TB] FAIL midrst_full got valid=%b digit=%h, required valid=1 digit=9",
                  bus.out_valid, bus.out_digit);
      end
      seg_in = SEG7_BLANK;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_digit, overrun} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL midrst_async got valid=%b digit=%h ovr=%b, required all 0",
                  bus.out_valid, bus.out_digit, overrun);
      end
      step(3);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_silent cycle=%0d got %b, required 0", i, bus.out_valid);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_latency();
      test_glitch();
      test_overrun();
      test_back_to_back();
      test_err_blank();
      test_reset_midstream();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL final_pending got %0d queued, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
